// File: rtl/conv_sched.sv
`default_nettype none
// ============================================================================
//  Module   : conv_sched
//  Purpose  : Frame scheduler for the grayscale / line-buffer / 3x3 conv chain.
//             Tracks raster coordinates, gates pixel valid into the pipeline,
//             latches the debounced filter switch at frame start, drains the
//             pipeline after the last pixel and flags stream-sync errors.
//  Revision : 1.0 - initial release
// ============================================================================
module conv_sched #(
  parameter int IMG_WIDTH    = 640,
  parameter int IMG_HEIGHT   = 480,
  parameter int DB_CYCLES    = 16,
  parameter int FLUSH_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_pixel_valid,
  input  logic [15:0] i_col_num,
  input  logic [15:0] i_row_num,
  input  logic        i_sw_in,
  output logic        o_pipe_en,
  output logic        o_mode_sel,
  output logic        o_frame_start,
  output logic        o_frame_end,
  output logic [15:0] o_line_count,
  output logic [7:0]  o_frame_count,
  output logic        o_sync_err,
  output logic        o_busy
);

  localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int FL_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  localparam logic [15:0]   c_LAST_COL  = 16'(IMG_WIDTH - 1);
  localparam logic [15:0]   c_LAST_ROW  = 16'(IMG_HEIGHT - 1);
  localparam logic [DB_W-1:0] c_DB_LAST = DB_W'(DB_CYCLES - 1);
  localparam logic [FL_W-1:0] c_FL_LAST = FL_W'(FLUSH_CYCLES - 1);
  // Coordinate expected right after the (0,0) start pixel
  localparam logic [15:0]   c_EXP0_COL  = (IMG_WIDTH == 1) ? 16'd0 : 16'd1;
  localparam logic [15:0]   c_EXP0_ROW  = (IMG_WIDTH == 1) ? 16'd1 : 16'd0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic            r_sync1;
  logic            r_sync2;
  logic            r_sw_db;
  logic [DB_W-1:0] r_db_cnt;

  logic [15:0]     r_exp_col;
  logic [15:0]     r_exp_row;
  logic [FL_W-1:0] r_flush_cnt;
  logic            r_mode_sel;
  logic            r_frame_start;
  logic            r_frame_end;
  logic [15:0]     r_line_count;
  logic [7:0]      r_frame_count;
  logic            r_sync_err;

  logic        w_at_origin;
  logic        w_start_px;
  logic        w_last_col;
  logic        w_last_px;
  logic        w_coord_ok;
  logic        w_flush_done;
  logic [15:0] w_next_col;
  logic [15:0] w_next_row;
  logic        w_begin;
  logic        w_restart;
  logic        w_take;
  logic        w_finish;

  assign w_at_origin  = (i_col_num == 16'd0) && (i_row_num == 16'd0);
  assign w_start_px   = i_pixel_valid && w_at_origin;
  assign w_last_col   = (i_col_num == c_LAST_COL);
  assign w_last_px    = w_last_col && (i_row_num == c_LAST_ROW);
  assign w_coord_ok   = (i_col_num == r_exp_col) && (i_row_num == r_exp_row);
  assign w_flush_done = (r_flush_cnt == c_FL_LAST);
  // Coordinate following the received one; used both on match and to resync
  assign w_next_col   = w_last_col ? 16'd0 : (i_col_num + 16'd1);
  assign w_next_row   = w_last_col ? (i_row_num + 16'd1) : i_row_num;

  // Switch synchronizer and debounce: accept a new level only after it has held
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_sw_db  <= 1'b0;
      r_db_cnt <= '0;
    end else begin
      r_sync1 <= i_sw_in;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_sw_db) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == c_DB_LAST) begin
        r_sw_db  <= r_sync2;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // FSM next state and per-cycle event decode
  always_comb begin
    w_state_nx = r_state;
    w_begin    = 1'b0;
    w_restart  = 1'b0;
    w_take     = 1'b0;
    w_finish   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_px) begin
          w_begin    = 1'b1;
          w_state_nx = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (i_pixel_valid) begin
          if (w_at_origin) begin
            // A new origin mid-frame aborts the current frame and restarts
            w_begin   = 1'b1;
            w_restart = 1'b1;
          end else begin
            w_take = 1'b1;
            if (w_last_px) begin
              w_state_nx = S_DRAIN;
            end
          end
        end
      end
      S_DRAIN: begin
        if (w_flush_done) begin
          w_finish   = 1'b1;
          w_state_nx = S_IDLE;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // Frame bookkeeping: coordinates, line/frame counters, mode latch, sync error
  always_ff @(posedge clk) begin
    if (rst) begin
      r_exp_col     <= '0;
      r_exp_row     <= '0;
      r_flush_cnt   <= '0;
      r_mode_sel    <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_end   <= 1'b0;
      r_line_count  <= '0;
      r_frame_count <= '0;
      r_sync_err    <= 1'b0;
    end else begin
      r_frame_start <= w_begin;
      r_frame_end   <= w_finish;
      r_flush_cnt   <= (r_state == S_DRAIN) ? (r_flush_cnt + 1'b1) : '0;

      if (w_begin) begin
        r_mode_sel   <= r_sw_db;
        r_line_count <= '0;
        r_exp_col    <= c_EXP0_COL;
        r_exp_row    <= c_EXP0_ROW;
      end else if (w_take) begin
        r_exp_col <= w_next_col;
        r_exp_row <= w_next_row;
        if (w_last_col && (r_line_count != 16'hFFFF)) begin
          r_line_count <= r_line_count + 16'd1;
        end
      end

      if (w_finish) begin
        r_frame_count <= r_frame_count + 8'd1;
      end

      // A restart shows as a one-cycle error pulse: set here, cleared by the
      // following cycle's frame_start unless another mismatch arrives then.
      if (w_begin && !w_restart) begin
        r_sync_err <= 1'b0;
      end else if (w_restart || (w_take && !w_coord_ok)) begin
        r_sync_err <= 1'b1;
      end else if (r_frame_start) begin
        r_sync_err <= 1'b0;
      end
    end
  end

  assign o_pipe_en     = i_pixel_valid && !rst &&
                         ((r_state == S_ACTIVE) || ((r_state == S_IDLE) && w_start_px));
  assign o_mode_sel    = r_mode_sel;
  assign o_frame_start = r_frame_start;
  assign o_frame_end   = r_frame_end;
  assign o_line_count  = r_line_count;
  assign o_frame_count = r_frame_count;
  assign o_sync_err    = r_sync_err;
  assign o_busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/conv_sched.md
# conv_sched

Frame-level scheduler for the grayscale → line-buffer → 3x3 convolution pipeline. It tracks the pixel stream's column and row coordinates, gates pixel validity into the pipeline, and latches the filter-select switch only at frame boundaries so a kernel never changes mid-image. It also drains the pipeline at end of frame and reports frame and line progress plus stream-sync errors. It sits between the sensor capture counters and the grayscale/buffer/convolution chain.

## Interface
- IMG_WIDTH, 640, active pixels per line.
- IMG_HEIGHT, 480, active lines per frame.
- DB_CYCLES, 16, cycles the synchronized switch must stay stable before it is accepted (≥2).
- FLUSH_CYCLES, 4, drain cycles after the last pixel before the frame is declared done (≥1).
- clk  in  1  pipeline clock.
- rst  in  1  reset; synchronous, active-high.
- pixel_valid  in  1  incoming pixel valid.
- col_num  in  16  incoming pixel column.
- row_num  in  16  incoming pixel row.
- sw_in  in  1  raw filter-select switch, asynchronous.
- pipe_en  out  1  gated valid to the grayscale stage.
- mode_sel  out  1  filter select to the convolution stage, frame-stable.
- frame_start  out  1  one-cycle pulse when a frame begins.
- frame_end  out  1  one-cycle pulse when the drain completes.
- line_count  out  16  completed lines in the current frame.
- frame_count  out  8  completed frames, wraps 255→0.
- sync_err  out  1  sticky coordinate-mismatch flag; cleared at the next frame_start.
- busy  out  1  high in ACTIVE and DRAIN.

## Operation
- Switch path: 2-flop synchronizer, then a debounce counter. sw_db takes the synchronized value after DB_CYCLES consecutive equal samples. Any change restarts the count.
- FSM states: IDLE, ACTIVE, DRAIN.
- **IDLE.** A valid pixel at (0,0) is the start condition. On it: go to ACTIVE, mode_sel←sw_db, line_count←0, sync_err←0, expected coordinate←(1,0) (or (0,1) if IMG_WIDTH=1).
- **ACTIVE.**
  - Each valid pixel is compared to the expected coordinate. On a mismatch, set sync_err and resynchronize the expected coordinate to the received coordinate + 1.
  - A valid pixel at col IMG_WIDTH-1 increments line_count.
  - A valid pixel at (IMG_WIDTH-1, IMG_HEIGHT-1) moves the FSM to DRAIN with the flush counter←0.
- **Restart.** A valid (0,0) while in ACTIVE is treated as an aborted frame and a restart:
  - sync_err is set for one cycle, then cleared by the new frame_start, so the abort is visible as a one-cycle pulse.
  - A new frame_start is issued and the IDLE start actions are applied.
  - No frame_end is issued and frame_count is unchanged.
- **DRAIN.** Pixels are ignored and pipe_en=0. The flush counter counts to FLUSH_CYCLES-1. At that point: frame_end pulse, frame_count+1 (mod 256), go to IDLE.
- pipe_en = pixel_valid when (state==ACTIVE) or (state==IDLE and start condition). Otherwise 0.
- **Counter widths.** line_count saturates at 16'hFFFF. Coordinate comparison uses the full 16 bits.

## Timing
- Reset values:
  - state=IDLE; pipe_en=0; mode_sel=0; frame_start=0; frame_end=0; line_count=0; frame_count=0; sync_err=0; busy=0.
  - Debounce counter=0; synchronizer flops=0; sw_db=0.
- **pipe_en** is combinational: zero latency from pixel_valid. The first pixel of a frame passes in the same cycle it arrives.
- **Registered outputs.** frame_start, mode_sel, line_count reset and busy update on the clock edge that accepts the start pixel. They are visible the cycle after that pixel.
- **Switch latency.** A sw_in edge reaches sw_db in 2 + DB_CYCLES cycles. mode_sel changes only at the next frame_start.
- **Drain timing.** frame_end asserts FLUSH_CYCLES cycles after the edge that accepts the last pixel. busy drops in the same cycle as frame_end.
- **rst mid-frame.** All state returns to reset values on the next edge. pipe_en is 0 while rst=1. There is no frame_end.
- **Simultaneous events.** A switch change during ACTIVE or DRAIN is held in sw_db and applied at the next frame start. A start pixel arriving in DRAIN is ignored: the frame is lost and no sync_err is raised.

## Test plan
- **Reset and idle.** Assert rst, then drive random pixel_valid with non-(0,0) coordinates in IDLE. Required: all outputs at reset values and pipe_en=0 throughout.
- **Clean frame.** IMG_WIDTH=4, IMG_HEIGHT=3, FLUSH_CYCLES=4; drive 12 valid pixels in raster order with gaps. Required:
  - pipe_en high exactly 12 times.
  - frame_start one cycle after pixel (0,0).
  - line_count steps 1, 2, 3.
  - frame_end 4 cycles after pixel (3,2); frame_count=1; sync_err=0.
- **Mid-frame switch toggle.** DB_CYCLES=16; toggle sw_in to 1 during frame 0. Required: mode_sel stays 0 until the frame-1 start, then becomes 1.
- **Switch glitch.** Pulse sw_in high for 10 cycles with DB_CYCLES=16. Required: sw_db and mode_sel never change.
- **Coordinate skip.** Skip pixel (2,1). Required: sync_err=1 from the next pixel until the next frame_start; frame still completes with frame_count+1.
- **Restart and reset mid-frame.** Case A: inject (0,0) at pixel 7. Required: new frame_start, no frame_end, frame_count unchanged, line_count←0. Case B: assert rst in DRAIN. Required: no frame_end, and all outputs at reset values.
